// File: rtl/pixel_pkg.sv
// Shared constants and state type for the frame-buffer pixel unstacker.
package pixel_pkg;

  localparam int unsigned PIX_W        = 16;
  localparam int unsigned WORD_W       = 128;
  localparam int unsigned PIX_PER_WORD = WORD_W / PIX_W;
  localparam int unsigned FRAME_WORDS  = 115200;
  localparam int unsigned WCNT_W       = 24;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } unstacker_state_t;

endpackage

// File: rtl/pixel_unstacker.sv
// Serialises packed frame-buffer words into one pixel per handshake, with a
// one-word prefetch slot and a word-count frame alignment check.
module pixel_unstacker #(
  parameter int unsigned PIX_W       = pixel_pkg::PIX_W,
  parameter int unsigned WORD_W      = pixel_pkg::WORD_W,
  parameter int unsigned FRAME_WORDS = pixel_pkg::FRAME_WORDS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] s_axis_data,
  input  logic              s_axis_tlast,
  input  logic              s_axis_valid,
  output logic              s_axis_ready,
  output logic [PIX_W-1:0]  m_axis_data,
  output logic              m_axis_tlast,
  output logic              m_axis_valid,
  input  logic              m_axis_ready,
  output logic              frame_sync_err
);

  import pixel_pkg::*;

  localparam int unsigned PPW   = WORD_W / PIX_W;
  localparam int unsigned IDX_W = (PPW > 1) ? $clog2(PPW) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(PPW - 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(FRAME_WORDS - 1);

  unstacker_state_t r_state;
  unstacker_state_t w_state_nxt;

  logic [WORD_W-1:0] r_cur;
  logic [WORD_W-1:0] r_nxt;
  logic              r_cur_tlast;
  logic              r_nxt_tlast;
  logic [IDX_W-1:0]  r_pidx;
  logic [WCNT_W-1:0] r_wcnt;
  logic              r_err;

  logic              w_in_hs;
  logic              w_out_hs;
  logic              w_last_pix;
  logic              w_load_cur_in;
  logic              w_load_cur_nxt;
  logic              w_load_nxt;
  logic              w_cnt_at_last;
  logic [PIX_W-1:0]  w_pix;

  assign s_axis_ready   = rst_n & (r_state != TWO);
  assign m_axis_valid   = (r_state != EMPTY);
  assign w_in_hs        = s_axis_valid & s_axis_ready;
  assign w_out_hs       = m_axis_valid & m_axis_ready;
  assign w_last_pix     = w_out_hs & (r_pidx == LAST_IDX);
  assign m_axis_data    = w_pix;
  assign m_axis_tlast   = r_cur_tlast & (r_pidx == LAST_IDX);
  assign frame_sync_err = r_err;
  assign w_cnt_at_last  = (r_wcnt == WCNT_LAST);

  always_comb begin
    w_pix = '0;
    for (int unsigned k = 0; k < PPW; k++) begin
      if (r_pidx == IDX_W'(k)) begin
        w_pix = r_cur[k*PIX_W +: PIX_W];
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_load_cur_in  = 1'b0;
    w_load_cur_nxt = 1'b0;
    w_load_nxt     = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_in_hs) begin
          w_state_nxt   = ONE;
          w_load_cur_in = 1'b1;
        end
      end
      ONE: begin
        if (w_in_hs && w_last_pix) begin
          w_load_cur_in = 1'b1;
        end else if (w_in_hs) begin
          w_state_nxt = TWO;
          w_load_nxt  = 1'b1;
        end else if (w_last_pix) begin
          w_state_nxt = EMPTY;
        end
      end
      TWO: begin
        if (w_last_pix) begin
          w_state_nxt    = ONE;
          w_load_cur_nxt = 1'b1;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cur       <= '0;
      r_cur_tlast <= 1'b0;
      r_nxt       <= '0;
      r_nxt_tlast <= 1'b0;
    end else begin
      if (w_load_cur_in) begin
        r_cur       <= s_axis_data;
        r_cur_tlast <= s_axis_tlast;
      end else if (w_load_cur_nxt) begin
        r_cur       <= r_nxt;
        r_cur_tlast <= r_nxt_tlast;
      end
      if (w_load_nxt) begin
        r_nxt       <= s_axis_data;
        r_nxt_tlast <= s_axis_tlast;
      end
    end
  end

  // pidx only moves on an output handshake, so it is already 0 whenever EMPTY loads CUR.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pidx <= '0;
    end else if (w_out_hs) begin
      r_pidx <= (r_pidx == LAST_IDX) ? '0 : r_pidx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wcnt <= '0;
      r_err  <= 1'b0;
    end else begin
      r_err <= w_in_hs & (s_axis_tlast ^ w_cnt_at_last);
      if (w_in_hs) begin
        r_wcnt <= (s_axis_tlast || w_cnt_at_last) ? '0 : r_wcnt + 1'b1;
      end
    end
  end

endmodule
